row_sel_driver: RTL and testbench

Sequencer that drives the real-valued row-address bus and wordline enable for one SRAM array access. It sits between the digital access controller and the analog-modelled row decoder. It accepts one row request per handshake and steps through precharge, address setup, wordline pulse and release phases. All analog-facing outputs are real rail voltages.

---
 rtl/row_sel_driver.sv | 207 ++++++++++++++++++++
 tb/tb_row_sel_driver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_sel_driver.sv
// -----------------------------------------------------------------------------
// row_sel_driver
//
// Sequences one SRAM row access: bitline precharge, row-address setup,
// wordline pulse and release. It accepts one request per handshake and has no
// queue. The analog-facing outputs are real rail voltages. Each one is a fixed
// VDD/VSS decode of a flop, so every output is effectively registered.
//
// Optional feature (compile-time macro):
//   ROW_SEL_LOOPBACK_EN  adds the row_fb input and the sticky err output. In
//                        the last wordline cycle the decoder's row outputs are
//                        thresholded at VTH and compared with one-hot(addr).
//                        Any mismatch (wrong row, no row, several rows) sets
//                        err, and err stays set until rst.
//
// Parameters:
//   ROWS     array rows (power of two, >= 2); AW = $clog2(ROWS)
//   PRE_CYC  precharge phase length in cycles (>= 1)
//   WL_CYC   wordline-high phase length in cycles (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  access request
//   req_ready  high only in IDLE (state decode)
//   req_addr   row index, sampled on accept
//   row_sel    real [0:AW-1] address bits to decoder (VDD/VSS)
//   row_en     real wordline enable, VDD only in WORDLINE
//   precharge  real bitline precharge, VDD only in PRECHARGE
//   busy       high in any state other than IDLE
//   done       one-cycle pulse in the first IDLE cycle after an access
//   row_fb     real [0:ROWS-1] decoder row outputs (loopback build only)
//   err        sticky loopback mismatch flag (loopback build only)
//
// Access timeline (T0 = cycle whose closing edge accepts the request):
//   PRECHARGE  T0+1 .. T0+PRE_CYC
//   SETUP      T0+PRE_CYC+1
//   WORDLINE   T0+PRE_CYC+2 .. T0+PRE_CYC+WL_CYC+1
//   RELEASE    T0+PRE_CYC+WL_CYC+2
//   IDLE+done  T0+PRE_CYC+WL_CYC+3 (a new request may be accepted here)
// -----------------------------------------------------------------------------
module row_sel_driver #(
  parameter  int ROWS    = 16,
  parameter  int PRE_CYC = 2,
  parameter  int WL_CYC  = 3,
  localparam int AW      = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output real           row_sel [0:AW-1],
  output real           row_en,
  output real           precharge,
  output logic          busy,
  output logic          done
`ifdef ROW_SEL_LOOPBACK_EN
  ,
  input  real           row_fb [0:ROWS-1],
  output logic          err
`endif
);

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;

  // One counter serves both timed phases, so it is sized for the longer one.
  localparam int CNT_MAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SETUP,
    S_WL,
    S_REL
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   sel_q;
  logic            en_q;
  logic            pre_q;
  logic            accept;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  // The address is data, not control. Reset leaves it alone, and it is only
  // visible on row_sel once sel_q is loaded in SETUP.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr;
    end
  end

  // Sequencer. The rail-driving bits change on the edge that enters a phase,
  // so each analog output follows its phase exactly with no decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sel_q <= '0;
      en_q  <= 1'b0;
      pre_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state <= S_PRE;
            cnt   <= CW'(PRE_CYC - 1);
            pre_q <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_PRE: begin
          if (cnt == '0) begin
            state <= S_SETUP;
            pre_q <= 1'b0;
            sel_q <= addr_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SETUP: begin
          state <= S_WL;
          cnt   <= CW'(WL_CYC - 1);
          en_q  <= 1'b1;
        end
        S_WL: begin
          if (cnt == '0) begin
            state <= S_REL;
            en_q  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_REL: begin
          // row_sel is held through RELEASE so the wordline falls on a
          // stable address. It drops to VSS as the sequencer reaches IDLE.
          state <= S_IDLE;
          sel_q <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          sel_q <= '0;
          en_q  <= 1'b0;
          pre_q <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Rail decode of the registered control bits.
  for (genvar s = 0; s < AW; s++) begin : g_sel
    assign row_sel[s] = sel_q[s] ? VDD : VSS;
  end

  assign row_en    = en_q  ? VDD : VSS;
  assign precharge = pre_q ? VDD : VSS;

`ifdef ROW_SEL_LOOPBACK_EN
  localparam real VTH = 0.8;

  logic [ROWS-1:0] fb_hit;
  logic [ROWS-1:0] onehot;
  logic            last_wl;

  always_comb begin
    fb_hit = '0;
    for (int i = 0; i < ROWS; i++) begin
      fb_hit[i] = (row_fb[i] >= VTH);
    end
  end

  assign onehot  = ROWS'(1) << addr_q;
  assign last_wl = (state == S_WL) && (cnt == '0);

  // Sample the decoder at the end of the wordline pulse, when it has had the
  // longest time to settle. err stays set until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (last_wl && (fb_hit != onehot)) begin
      err <= 1'b1;
    end
  end
`endif

  // Safety properties of the analog-facing outputs.
  a_pre_en_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(pre_q && en_q)
  );

  a_sel_stable_in_wl : assert property (
    @(posedge clk) disable iff (rst) (en_q && $past(en_q)) |-> $stable(sel_q)
  );

endmodule

// File: tb/tb_row_sel_driver.sv
// -----------------------------------------------------------------------------
// Testbench for row_sel_driver with default parameters.
// A timeline model records how many cycles have passed since the last accept.
// Every output is derived from that age and the latched address. One compare
// process checks the DUT against the model on every negative clock edge.
// Directed scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_row_sel_driver;

  localparam int  ROWS    = 16;
  localparam int  PRE_CYC = 2;
  localparam int  WL_CYC  = 3;
  localparam int  AW      = 4;
  localparam int  D       = PRE_CYC + WL_CYC + 3;   // age of the done cycle
  localparam real VDD     = 1.5;
  localparam real VSS     = 0.0;
  localparam real VTH     = 0.8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          busy;
  logic          done;
  real           row_sel [0:AW-1];
  real           row_en;
  real           precharge;
`ifdef ROW_SEL_LOOPBACK_EN
  real           row_fb [0:ROWS-1];
  logic          err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  row_sel_driver #(
    .ROWS    (ROWS),
    .PRE_CYC (PRE_CYC),
    .WL_CYC  (WL_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .row_sel   (row_sel),
    .row_en    (row_en),
    .precharge (precharge),
    .busy      (busy),
    .done      (done)
`ifdef ROW_SEL_LOOPBACK_EN
    ,
    .row_fb    (row_fb),
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_r(input string nm, input real act, input real exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %f expected %f", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: m_k is the age of the current access in cycles. Age 0 means idle
  // with no access, age 1 is the first cycle after the accept edge, and age D
  // is the done cycle (idle, ready for a new request).
  // ---------------------------------------------------------------------------
  int            m_k = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_err = 1'b0;

`ifdef ROW_SEL_LOOPBACK_EN
  function automatic logic fb_ok(input logic [AW-1:0] a);
    int n = 0;
    for (int i = 0; i < ROWS; i++) if (row_fb[i] >= VTH) n++;
    return (n == 1) && (row_fb[a] >= VTH);
  endfunction
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k   <= 0;
      m_err <= 1'b0;
    end else begin
`ifdef ROW_SEL_LOOPBACK_EN
      if (m_k == PRE_CYC + WL_CYC + 1 && !fb_ok(m_addr)) m_err <= 1'b1;
`endif
      if (req_valid && (m_k == 0 || m_k == D)) begin
        m_k    <= 1;
        m_addr <= req_addr;
      end else if (m_k == D) begin
        m_k <= 0;
      end else if (m_k > 0) begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk_b("req_ready", req_ready, (m_k == 0 || m_k == D));
      chk_b("busy", busy, !(m_k == 0 || m_k == D));
      chk_b("done", done, (m_k == D));
      chk_r("precharge", precharge, (m_k >= 1 && m_k <= PRE_CYC) ? VDD : VSS);
      chk_r("row_en", row_en,
            (m_k >= PRE_CYC + 2 && m_k <= PRE_CYC + WL_CYC + 1) ? VDD : VSS);
      for (int s = 0; s < AW; s++) begin
        chk_r("row_sel", row_sel[s],
              (m_k >= PRE_CYC + 1 && m_k <= PRE_CYC + WL_CYC + 2 && m_addr[s])
              ? VDD : VSS);
      end
`ifdef ROW_SEL_LOOPBACK_EN
      chk_b("err", err, m_err);
`endif
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents a request in the current cycle, so the returned t0 is the cycle
  // whose closing edge accepts it. Returns one cycle later with valid low.
  task automatic run_access(input logic [AW-1:0] a, output int t0);
    t0        = cyc;
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int target, input int limit);
    for (int i = 0; i < limit && done_cnt < target; i++) step();
    chk_i(nm, done_cnt, target);
  endtask

  task automatic chk_idle_lits(input string nm);
    chk_b({nm, "_ready"}, req_ready, 1'b1);
    chk_b({nm, "_busy"}, busy, 1'b0);
    chk_b({nm, "_done"}, done, 1'b0);
    chk_r({nm, "_row_en"}, row_en, 0.0);
    chk_r({nm, "_precharge"}, precharge, 0.0);
    for (int s = 0; s < AW; s++) chk_r({nm, "_row_sel"}, row_sel[s], 0.0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d1;
    int dc0;
    logic [7:0] pre_tbl;
    logic [7:0] en_tbl;
    logic [7:0] sel_tbl;
    logic [7:0] done_tbl;

`ifdef ROW_SEL_LOOPBACK_EN
    for (int i = 0; i < ROWS; i++) row_fb[i] = 0.0;
`endif

    // Reset, then 5 idle cycles.
    repeat (2) @(posedge clk);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk_idle_lits("reset_idle");

    // Single access to row 4'hA. Table bit k-1 describes cycle T0+k.
    pre_tbl  = 8'b0000_0011;
    sel_tbl  = 8'b0111_1100;
    en_tbl   = 8'b0011_1000;
    done_tbl = 8'b1000_0000;
    run_access(4'hA, t0);
    for (int k = 1; k <= 8; k++) begin
      chk_r("a_precharge", precharge, pre_tbl[k-1] ? 1.5 : 0.0);
      chk_r("a_row_en", row_en, en_tbl[k-1] ? 1.5 : 0.0);
      chk_r("a_row_sel0", row_sel[0], 0.0);
      chk_r("a_row_sel1", row_sel[1], sel_tbl[k-1] ? 1.5 : 0.0);
      chk_r("a_row_sel2", row_sel[2], 0.0);
      chk_r("a_row_sel3", row_sel[3], sel_tbl[k-1] ? 1.5 : 0.0);
      chk_b("a_done", done, done_tbl[k-1]);
      if (k < 8) step();
    end
    chk_i("a_done_latency", done_cyc - t0, 8);

    // Back-to-back: valid held high; addr 3 first, then 12 after the accept.
    step();
    dc0       = done_cnt;
    t0        = cyc;
    req_valid = 1'b1;
    req_addr  = 4'd3;
    step();
    req_addr  = 4'd12;
    wait_done("b2b_first_done", dc0 + 1, 20);
    d1 = done_cyc;
    chk_i("b2b_first_latency", d1 - t0, 8);
    step();
    req_valid = 1'b0;
    step();
    step();
    chk_r("b2b_sel0", row_sel[0], 0.0);
    chk_r("b2b_sel1", row_sel[1], 0.0);
    chk_r("b2b_sel2", row_sel[2], 1.5);
    chk_r("b2b_sel3", row_sel[3], 1.5);
    wait_done("b2b_second_done", dc0 + 2, 20);
    chk_i("b2b_period", done_cyc - d1, 8);

    // Request while busy is ignored.
    step();
    dc0 = done_cnt;
    run_access(4'd9, t0);
    step();
    step();
    req_valid = 1'b1;
    req_addr  = 4'd5;
    step();
    req_valid = 1'b0;
    chk_r("ign_row_en", row_en, 1.5);
    chk_r("ign_sel0", row_sel[0], 1.5);
    chk_r("ign_sel2", row_sel[2], 0.0);
    wait_done("ign_done", dc0 + 1, 20);
    chk_i("ign_latency", done_cyc - t0, 8);
    repeat (10) step();
    chk_i("ign_single_done", done_cnt, dc0 + 1);

    // Asynchronous reset during WORDLINE.
    dc0 = done_cnt;
    run_access(4'd7, t0);
    repeat (4) step();
    chk_r("rstwl_in_wl", row_en, 1.5);
    #1;
    rst = 1'b1;
    #1;
    chk_idle_lits("rstwl_async");
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    chk_i("rstwl_no_done", done_cnt, dc0);
    run_access(4'd2, t0);
    wait_done("rstwl_next_done", dc0 + 1, 20);
    chk_i("rstwl_next_latency", done_cyc - t0, 8);

`ifdef ROW_SEL_LOOPBACK_EN
    // Loopback: clean decode, wrong row, then clean again; err is sticky.
    step();
    #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    chk_b("lb_err_cleared", err, 1'b0);
    row_fb[6] = 1.5;
    dc0 = done_cnt;
    run_access(4'd6, t0);
    wait_done("lb_clean_done", dc0 + 1, 20);
    chk_b("lb_clean_err", err, 1'b0);
    row_fb[6] = 0.0;
    row_fb[7] = 1.5;
    step();
    run_access(4'd6, t0);
    wait_done("lb_bad_done", dc0 + 2, 20);
    chk_b("lb_bad_err", err, 1'b1);
    row_fb[7] = 0.0;
    row_fb[6] = 1.5;
    step();
    run_access(4'd6, t0);
    wait_done("lb_sticky_done", dc0 + 3, 20);
    chk_b("lb_sticky_err", err, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_b("lb_err_rst", err, 1'b0);
    step();
    rst = 1'b0;
    step();
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
